// File: rtl/n_bit_pipe_reg.sv
// Elastic pipeline stage: valid/ready handshake, synchronous flush, optional skid entry.
// Define N_BIT_PIPE_REG_SKID_EN for the two-entry build with a registered in_ready.
//
// state | meaning
// EMPTY | no entry held, out_valid low
// ONE   | head entry in main register
// TWO   | head in main, second entry in skid register (skid build only)
module n_bit_pipe_reg #(
  parameter int            N           = 32,
  parameter logic [N-1:0]  RESET_VALUE = '0,
  parameter logic [N-1:0]  CLR_VALUE   = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] main_q;
  logic         in_fire;
  logic         out_fire;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign count     = state;

`ifdef N_BIT_PIPE_REG_SKID_EN
  logic [N-1:0] skid_q;
  logic         in_ready_q;

  // in_ready is registered so out_ready never reaches upstream combinationally;
  // it only changes on transitions into or out of TWO.
  assign in_ready = in_ready_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      main_q     <= RESET_VALUE;
      skid_q     <= RESET_VALUE;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      state      <= EMPTY;
      main_q     <= CLR_VALUE;
      skid_q     <= CLR_VALUE;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end else if (in_fire) begin
            skid_q     <= in_data;
            state      <= TWO;
            in_ready_q <= 1'b0;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_q     <= skid_q;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= EMPTY;
      main_q <= RESET_VALUE;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= CLR_VALUE;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          // in_ready is high whenever out_fire is, so a new entry replaces the leaving one
          if (in_fire) begin
            main_q <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_n_bit_pipe_reg.sv
// Directed and random-handshake bench for n_bit_pipe_reg; covers both builds
// depending on whether N_BIT_PIPE_REG_SKID_EN is defined.
module tb_n_bit_pipe_reg;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  count;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [31:0] RST_V = 32'h13;
  localparam logic [31:0] CLR_V = 32'h5A;

  n_bit_pipe_reg #(.N(32), .RESET_VALUE(RST_V), .CLR_VALUE(CLR_V)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0h expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== RST_V) $display("FAIL reset_out_data: got %0h expected %0h", out_data, RST_V); else pass_cnt++;
    total_cnt++; if (count !== 2'd0) $display("FAIL reset_count: got %0d expected 0", count); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0h expected 1", in_ready); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %0h expected 1", i, in_ready); else pass_cnt++;
      tick;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL stream_out_valid[%0d]: got %0h expected 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 32'(i)) $display("FAIL stream_out_data[%0d]: got %0h expected %0h", i, out_data, i); else pass_cnt++;
      total_cnt++; if (count !== 2'd1) $display("FAIL stream_count[%0d]: got %0d expected 1", i, count); else pass_cnt++;
    end
    in_valid = 1'b0;
    tick;
    total_cnt++; if (count !== 2'd0) $display("FAIL stream_drain_count: got %0d expected 0", count); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    bit          sent;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick;
    total_cnt++; if (count !== 2'd1) $display("FAIL bp_count_a: got %0d expected 1", count); else pass_cnt++;
    in_data = 32'hB;
`ifdef N_BIT_PIPE_REG_SKID_EN
    tick;
    total_cnt++; if (count !== 2'd2) $display("FAIL bp_count_two: got %0d expected 2", count); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0h expected 0", in_ready); else pass_cnt++;
    in_data = 32'hC;
    for (int k = 0; k < 3; k++) begin
      tick;
      total_cnt++; if (out_data !== 32'hA || out_valid !== 1'b1 || count !== 2'd2)
        $display("FAIL bp_hold[%0d]: got data %0h valid %0h count %0d expected a 1 2", k, out_data, out_valid, count); else pass_cnt++;
    end
    exp_q = '{32'hA, 32'hB, 32'hC};
`else
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_comb: got %0h expected 0", in_ready); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      tick;
      total_cnt++; if (out_data !== 32'hA || count !== 2'd1)
        $display("FAIL bp_hold[%0d]: got data %0h count %0d expected a 1", k, out_data, count); else pass_cnt++;
    end
    exp_q = '{32'hA, 32'hB};
`endif
    out_ready = 1'b1;
    sent = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
`ifndef N_BIT_PIPE_REG_SKID_EN
      if (k == 0) begin
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_release: got %0h expected 1", in_ready); else pass_cnt++;
      end
`endif
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) sent = 1'b1;
      tick;
      if (sent) in_valid = 1'b0;
    end
    total_cnt++; if (got.size() != exp_q.size()) $display("FAIL bp_out_count: got %0d expected %0d", got.size(), exp_q.size()); else pass_cnt++;
    for (int k = 0; k < exp_q.size(); k++) begin
      total_cnt++; if (k >= got.size() || got[k] !== exp_q[k])
        $display("FAIL bp_order[%0d]: got %0h expected %0h", k, (k < got.size()) ? got[k] : 32'hx, exp_q[k]); else pass_cnt++;
    end
    total_cnt++; if (count !== 2'd0) $display("FAIL bp_final_count: got %0d expected 0", count); else pass_cnt++;
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h21;
    tick;
    flush   = 1'b1;
    in_data = 32'hEE;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush1_in_ready_pre: got %0h expected 1", in_ready); else pass_cnt++;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    total_cnt++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL flush1_empty: got count %0d valid %0h expected 0 0", count, out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== CLR_V) $display("FAIL flush1_out_data: got %0h expected %0h", out_data, CLR_V); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush1_in_ready: got %0h expected 1", in_ready); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush1_no_ghost[%0d]: got %0h expected 0", k, out_valid); else pass_cnt++;
    end
`ifdef N_BIT_PIPE_REG_SKID_EN
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h31;
    tick;
    in_data = 32'h32;
    tick;
    total_cnt++; if (count !== 2'd2) $display("FAIL flush2_setup_count: got %0d expected 2", count); else pass_cnt++;
    flush   = 1'b1;
    in_data = 32'hEE;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    total_cnt++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL flush2_empty: got count %0d valid %0h expected 0 0", count, out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== CLR_V) $display("FAIL flush2_out_data: got %0h expected %0h", out_data, CLR_V); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush2_in_ready: got %0h expected 1", in_ready); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush2_no_ghost[%0d]: got %0h expected 0", k, out_valid); else pass_cnt++;
    end
`endif
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h41;
    tick;
    in_data = 32'h42;
    tick;
    in_data = 32'h43;
    total_cnt++; if (out_data !== 32'h42 || count !== 2'd1) $display("FAIL areset_setup: got data %0h count %0d expected 42 1", out_data, count); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL areset_out_valid: got %0h expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== RST_V) $display("FAIL areset_out_data: got %0h expected %0h", out_data, RST_V); else pass_cnt++;
    total_cnt++; if (count !== 2'd0) $display("FAIL areset_count: got %0d expected 0", count); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready: got %0h expected 1", in_ready); else pass_cnt++;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    total_cnt++; if (count !== 2'd0) $display("FAIL areset_after_count: got %0d expected 0", count); else pass_cnt++;
  endtask

  task automatic test_random;
    logic [31:0] q[$];
    bit          prev_stall;
    logic [31:0] prev_data;
    bit          accepted;
    int          errs;
    errs = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      total_cnt++;
      if (count !== 2'(q.size()) || out_valid !== (q.size() != 0)) begin
        if (errs < 10) $display("FAIL rand_count[%0d]: got %0d valid %0h expected %0d", cyc, count, out_valid, q.size());
        errs++;
      end else pass_cnt++;
      if (q.size() != 0) begin
        total_cnt++;
        if (out_data !== q[0]) begin
          if (errs < 10) $display("FAIL rand_order[%0d]: got %0h expected %0h", cyc, out_data, q[0]);
          errs++;
        end else pass_cnt++;
      end
      if (prev_stall) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          if (errs < 10) $display("FAIL rand_stall[%0d]: got %0h expected %0h", cyc, out_data, prev_data);
          errs++;
        end else pass_cnt++;
      end
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      accepted = in_valid && in_ready;
      if (accepted) q.push_back(in_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      tick;
      if (accepted) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5 && q.size() != 0; k++) begin
      #1;
      total_cnt++; if (out_data !== q[0]) $display("FAIL rand_drain[%0d]: got %0h expected %0h", k, out_data, q[0]); else pass_cnt++;
      if (out_valid) void'(q.pop_front());
      tick;
    end
    total_cnt++; if (q.size() != 0 || count !== 2'd0) $display("FAIL rand_final: got count %0d left %0d expected 0 0", count, q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_flush;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
